// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel pipeline: pixel type, default image size,
// and the 3-pixel window row used by the window generator.
package sobel_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;

  // Shared with the masking stage so both agree on frame geometry.
  localparam int IMG_W_DEFAULT = 640;
  localparam int IMG_H_DEFAULT = 480;

  // One row of the 3x3 window: left, centre, right.
  typedef struct packed {
    pix_t l;
    pix_t c;
    pix_t r;
  } row3_t;

  // Shift a window row left by one pixel, entering p on the right.
  function automatic row3_t shift_in(input row3_t w, input pix_t p);
    row3_t res;
    res.l = w.c;
    res.c = w.r;
    res.r = p;
    return res;
  endfunction

endpackage

// File: rtl/sobel_window_if.sv
// Pixel-in / window-out bundle of sobel_window. in_sof exists only when
// SOBEL_WIN_SOF_EN is defined.
interface sobel_window_if;
  import sobel_pkg::*;

  logic in_valid;
  pix_t in_pix;
`ifdef SOBEL_WIN_SOF_EN
  logic in_sof;
`endif
  logic out_valid;
  logic out_last;
  pix_t pix_0, pix_1, pix_2;
  pix_t pix_3, pix_5;
  pix_t pix_6, pix_7, pix_8;

  // Pixel source / window consumer side.
  modport master (
`ifdef SOBEL_WIN_SOF_EN
    output in_sof,
`endif
    output in_valid, in_pix,
    input  out_valid, out_last,
    input  pix_0, pix_1, pix_2, pix_3, pix_5, pix_6, pix_7, pix_8
  );

  // Window generator side.
  modport slave (
`ifdef SOBEL_WIN_SOF_EN
    input  in_sof,
`endif
    input  in_valid, in_pix,
    output out_valid, out_last,
    output pix_0, pix_1, pix_2, pix_3, pix_5, pix_6, pix_7, pix_8
  );

endinterface

// File: rtl/sobel_line_buf.sv
// Two-row line buffer: combinational read-first access, synchronous write.
// rd_row1 returns the previous row, rd_row2 the row before it.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pix_t          wdata,
  output pix_t          rd_row1,
  output pix_t          rd_row2
);

  pix_t lb0 [DEPTH];
  pix_t lb1 [DEPTH];

  // Asynchronous read keeps this in distributed RAM; the write below uses the
  // old lb0 entry, so the same-cycle read always sees pre-write data.
  assign rd_row1 = lb0[addr];
  assign rd_row2 = lb1[addr];

  // NOTE: the arrays have no reset; a reset port would forbid RAM mapping, and
  // stale contents are never visible because row gating masks them.
  always_ff @(posedge clk) begin
    if (we) begin
      lb1[addr] <= lb0[addr];
      lb0[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sobel_window.sv
// Streaming 3x3 window generator feeding the Sobel masking stage.
// Optional in_sof frame alignment is enabled with `define SOBEL_WIN_SOF_EN.
module sobel_window
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEFAULT,
  parameter int IMG_H = IMG_H_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  sobel_window_if.slave bus
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic             accept;
  logic             sof;
  logic [COL_W-1:0] col_q, col_cur;
  logic [ROW_W-1:0] row_q, row_cur;
  logic             win_ok;
  pix_t             lb0_rd, lb1_rd;
  row3_t            top_q, mid_q, bot_q;
  logic             out_valid_q, out_last_q;

  assign accept = bus.in_valid;

`ifdef SOBEL_WIN_SOF_EN
  assign sof = bus.in_valid & bus.in_sof;
`else
  assign sof = 1'b0;
`endif

  // A start-of-frame pixel is treated as (0,0); its column of 0 also keeps it
  // from producing a window.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    col_cur = col_q;
    row_cur = row_q;
    if (sof) begin
      col_cur = '0;
      row_cur = '0;
    end
    win_ok = (row_cur >= ROW_W'(2)) && (col_cur >= COL_W'(2));
  end

  sobel_line_buf #(
    .DEPTH (IMG_W),
    .AW    (COL_W)
  ) u_line_buf (
    .clk     (clk),
    .we      (accept),
    .addr    (col_cur),
    .wdata   (bus.in_pix),
    .rd_row1 (lb0_rd),
    .rd_row2 (lb1_rd)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_cur == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_cur == ROW_LAST) ? '0 : row_cur + ROW_W'(1);
      end else begin
        col_q <= col_cur + COL_W'(1);
        row_q <= row_cur;
      end
    end
  end

  // Window registers double as the pix_* output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_q <= '0;
      mid_q <= '0;
      bot_q <= '0;
    end else if (accept) begin
      top_q <= shift_in(top_q, lb1_rd);
      mid_q <= shift_in(mid_q, lb0_rd);
      bot_q <= shift_in(bot_q, bus.in_pix);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= accept && win_ok;
      out_last_q  <= accept && win_ok && (row_cur == ROW_LAST) && (col_cur == COL_LAST);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.pix_0     = top_q.l;
  assign bus.pix_1     = top_q.c;
  assign bus.pix_2     = top_q.r;
  assign bus.pix_3     = mid_q.l;
  assign bus.pix_5     = mid_q.r;
  assign bus.pix_6     = bot_q.l;
  assign bus.pix_7     = bot_q.c;
  assign bus.pix_8     = bot_q.r;

endmodule

// File: tb/tb_sobel_window.sv
// Self-checking bench for sobel_window on a 4x4 image: a frame-array model
// predicts every window, strobe and last flag from raster positions.
module tb_sobel_window;
  import sobel_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sobel_window_if bus();

  sobel_window #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks  = 0;
  int   errors  = 0;
  int   strobes = 0;
  int   m_row   = 0;
  int   m_col   = 0;
  pix_t img [H][W];

  function automatic pix_t pat(input int r, input int c);
    return pix_t'(16 * r + c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, predict its outcome from the frame model, check 1 cycle later.
  task automatic drive(input logic v, input pix_t p, input logic s);
    logic ev;
    logic el;
    int   r;
    int   c;
    pix_t ew [8];
    pix_t ob [8];
    @(negedge clk);
    bus.in_valid = v;
    bus.in_pix   = p;
`ifdef SOBEL_WIN_SOF_EN
    bus.in_sof   = s;
`endif
    ev = 1'b0;
    el = 1'b0;
    ew = '{default: '0};
    if (v) begin
      if (s) begin
        m_row = 0;
        m_col = 0;
      end
      r = m_row;
      c = m_col;
      img[r][c] = p;
      ev = (r >= 2) && (c >= 2);
      el = ev && (r == H - 1) && (c == W - 1);
      if (ev)
        ew = '{img[r-2][c-2], img[r-2][c-1], img[r-2][c],
               img[r-1][c-2], img[r-1][c],
               img[r][c-2],   img[r][c-1],   img[r][c]};
      m_col = (c + 1) % W;
      if (c == W - 1) m_row = (r + 1) % H;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("out_last", 32'(bus.out_last), 32'(el));
    if (ev) begin
      ob = '{bus.pix_0, bus.pix_1, bus.pix_2, bus.pix_3, bus.pix_5,
             bus.pix_6, bus.pix_7, bus.pix_8};
      for (int k = 0; k < 8; k++)
        chk($sformatf("win_slot%0d@(%0d,%0d)", k, r, c), 32'(ob[k]), 32'(ew[k]));
    end
    if (bus.out_valid === 1'b1) strobes++;
  endtask

  // One complete frame; gaps inserts 0..2 idle cycles before each pixel.
  task automatic frame(input bit rnd, input bit gaps);
    strobes = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gaps) repeat ($urandom_range(2)) drive(1'b0, pix_t'($urandom), 1'b0);
        drive(1'b1, rnd ? pix_t'($urandom) : pat(r, c), 1'b0);
      end
    end
    chk("strobe_count", 32'(strobes), 32'((W - 2) * (H - 2)));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_last"}, 32'(bus.out_last), 32'd0);
    chk({tag, "_pix"}, 32'(bus.pix_0 | bus.pix_1 | bus.pix_2 | bus.pix_3 |
                            bus.pix_5 | bus.pix_6 | bus.pix_7 | bus.pix_8), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_pix   = '0;
`ifdef SOBEL_WIN_SOF_EN
    bus.in_sof   = 1'b0;
`endif

    // Held in reset with random activity: outputs stay at zero.
    repeat (6) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom);
      bus.in_pix   = pix_t'($urandom);
      @(posedge clk);
      #1;
      chk_all_zero("in_reset");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;

    // Full frame, continuous: directed values on first and last windows.
    strobes = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        drive(1'b1, pat(r, c), 1'b0);
        if (r == 2 && c == 2) begin
          chk("first_pix_0", 32'(bus.pix_0), 32'h00);
          chk("first_pix_1", 32'(bus.pix_1), 32'h01);
          chk("first_pix_2", 32'(bus.pix_2), 32'h02);
          chk("first_pix_3", 32'(bus.pix_3), 32'h10);
          chk("first_pix_5", 32'(bus.pix_5), 32'h12);
          chk("first_pix_6", 32'(bus.pix_6), 32'h20);
          chk("first_pix_7", 32'(bus.pix_7), 32'h21);
          chk("first_pix_8", 32'(bus.pix_8), 32'h22);
        end
        if (r == 3 && c == 3) begin
          chk("fourth_last", 32'(bus.out_last), 32'd1);
          chk("fourth_pix_0", 32'(bus.pix_0), 32'h11);
          chk("fourth_pix_8", 32'(bus.pix_8), 32'h33);
        end
      end
    end
    chk("frame1_strobes", 32'(strobes), 32'd4);

    // Idle gaps, then two back-to-back frames.
    frame(1'b0, 1'b1);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);

    // Reset mid-frame after (2,1), then restart from (0,0).
    for (int i = 0; i < 2 * W + 2; i++)
      drive(1'b1, pat(i / W, i % W), 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst   = 1'b1;
    m_row = 0;
    m_col = 0;
    frame(1'b0, 1'b0);

    // Random pixel data, with and without gaps.
    frame(1'b1, 1'b1);
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b1);

`ifdef SOBEL_WIN_SOF_EN
    // Stream up to (1,2), then in_sof at (1,3) realigns to a fresh frame.
    for (int i = 0; i < W + 3; i++)
      drive(1'b1, pat(i / W, i % W), 1'b0);
    strobes = 0;
    drive(1'b1, pat(0, 0), 1'b1);
    chk("sof_no_strobe", 32'(bus.out_valid), 32'd0);
    for (int i = 1; i < W * H; i++)
      drive(1'b1, pat(i / W, i % W), 1'b0);
    chk("sof_frame_strobes", 32'(strobes), 32'd4);
`endif

    repeat (2) drive(1'b0, '0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_window.md
# sobel_window

Streaming 3x3 window generator that feeds the Sobel masking stage. It accepts a raster-order 8-bit pixel stream, one pixel per enabled cycle, and buffers the two previous image rows in line buffers. For every interior pixel it presents the eight neighbour pixels on registered outputs with a valid strobe, and marks the last window of each frame. It sits between the pixel source and the masking stage.

## Interface
- IMG_W, default 640: image width in pixels; must be ≥ 3.
- IMG_H, default 480: image height in lines; must be ≥ 3.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_pix is accepted on this cycle.
- in_pix  in  8  input pixel, raster order (left→right, top→bottom).
- in_sof  in  1  start of frame; the port exists only with SOBEL_WIN_SOF_EN.
- out_valid  out  1  window outputs are valid; one-cycle strobe per window.
- out_last  out  1  asserted with out_valid on the final window of a frame.
- pix_0, pix_1, pix_2  out  8 each  top row: left, centre, right.
- pix_3, pix_5  out  8 each  middle row: left, right. The centre pixel is not output.
- pix_6, pix_7, pix_8  out  8 each  bottom row: left, centre, right.

## Operation
- **Counters**
  - col counts 0..IMG_W-1 and row counts 0..IMG_H-1. Widths are $clog2(IMG_W) and $clog2(IMG_H).
  - Both advance only on an accepted pixel.
  - At col=IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0. The next pixel starts a new frame.
- **Line buffers**
  - Two buffers, each IMG_W × 8 bits: lb0 holds row-1 and lb1 holds row-2.
  - On an accepted pixel at column c, read lb1[c] and lb0[c] first, then write lb1[c]←lb0[c] and lb0[c]←in_pix. Read-first, same cycle.
- **Window**
  - Three 3-entry shift registers (top, mid, bot) shift left on each accepted pixel.
  - The new right column is {top=lb1[c], mid=lb0[c], bot=in_pix}.
- **Output rule**
  - An accept at (row, col) with row ≥ 2 and col ≥ 2 produces a window centred at (row-1, col-1).
  - pix_0 = (row-2, col-2), pix_2 = (row-2, col), pix_8 = (row, col), and the rest follow the same grid.
  - Each frame produces (IMG_W-2)·(IMG_H-2) windows. Border centres produce no output.
- **Last window:** out_last is asserted with the window from the accept at (IMG_H-1, IMG_W-1).
- **Gating:** windows straddling a row wrap or a frame wrap never assert out_valid; the col ≥ 2 and row ≥ 2 gating enforces this.
- **Line buffer contents** are not reset. Stale data is masked by the row gating.

## Timing
- Latency: out_valid and the pix_* outputs update 1 cycle after the accepting edge.
- Throughput: one window per cycle, sustained with in_valid continuously high.
- **in_valid low:**
  - Counters, buffers and window hold.
  - out_valid and out_last are 0 on the next cycle.
  - pix_* outputs hold their last values.
- **Reset values:** out_valid=0, out_last=0, all pix_*=0, col=0, row=0, window registers=0.
- **Reset mid-frame:** takes effect immediately (asynchronous). The first pixel after release is treated as (0,0).
- There is no backpressure; the downstream stage must accept every strobe.

## Configuration
- **SOBEL_WIN_SOF_EN defined:**
  - The in_sof port is present.
  - An accepted pixel with in_sof=1 is forced to (0,0): it is written to column 0, and counters become col=1, row=0 after the cycle.
  - A pending out_valid for that cycle is suppressed.
- **Not defined:** no in_sof port; frame alignment comes from the counters only.

## Structure
- Shared package sobel_pkg holds:
  - the pixel width constant PIX_W=8;
  - the pixel typedef pix_t;
  - the default IMG_W and IMG_H constants, shared with the masking stage.
- One sub-module, sobel_line_buf: the two-row buffer with read-first semantics, combinational read and synchronous write, implemented as distributed RAM.
- sobel_window contains the counters, window shift registers, gating and output registers.

## Test plan
Tests 2–6 use IMG_W=4, IMG_H=4, with pixel value = 16·row + col.
1. **Reset:** rst=0 with random in_valid/in_pix → all outputs 0 throughout; after release, no out_valid until pixel (2,2) is accepted.
2. **Full frame, continuous in_valid:**
   - First out_valid comes 1 cycle after (2,2) with pix_0..pix_8 = 00, 01, 02, 10, 12, 20, 21, 22.
   - Exactly 4 strobes occur.
   - The 4th strobe has out_last=1, pix_0=11 and pix_8=33.
3. **Random idle gaps on in_valid:** the same 4 windows with identical values; out_valid=0 on every cycle following an idle cycle.
4. **Two back-to-back frames:** frame 2 yields the same 4 windows; no strobe occurs during frame 2 rows 0–1.
5. **Reset mid-frame:** reset after (2,1), then restart the frame from (0,0) → no stale strobe; 4 correct windows follow.
6. **With SOBEL_WIN_SOF_EN:** assert in_sof at stream position (1,3) → no strobe on that cycle; the subsequent frame produces 4 correct windows.
